// File: rtl/tile_dark_mixer_pkg.sv
// Shared types and elaboration-time helpers for the tile dark mixer.
package tile_dark_mixer_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT    = 2'd0,
        MODE_INV       = 2'd1,
        MODE_BLK_DARK  = 2'd2,
        MODE_BLK_LIGHT = 2'd3
    } mode_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int width_of(input int v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Size of the final (possibly partial) tile along one axis.
    function automatic int last_len(input int total, input int k);
        return total - (ceil_div(total, k) - 1) * k;
    endfunction

endpackage

// File: rtl/tile_dark_mixer_if.sv
// Video stream bundle: syncs, data enable and pixel data.
interface tile_dark_mixer_if #(parameter int DW = 24);
    logic          hs;
    logic          vs;
    logic          de;
    logic [DW-1:0] data;

    modport master (output hs, vs, de, data);
    modport slave  (input  hs, vs, de, data);
endinterface

// File: rtl/tile_dark_mixer_accum.sv
// One tile row of gray accumulators plus the per-column bright decision.
// TILE_HYST_EN selects the hysteresis compare instead of a plain threshold.
module tile_accum
    import tile_dark_mixer_pkg::*;
#(
    parameter int H_WIDTH  = 1920,
    parameter int V_HEIGHT = 1080,
    parameter int KH       = 30,
    parameter int KV       = 30,
    parameter int GW       = 3,
    parameter int THR      = 4,
    parameter int HYST     = 1,
    localparam int TH      = ceil_div(H_WIDTH, KH),
    localparam int CW      = width_of(TH + 1)
) (
    input  logic          vin_clk_i,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          acc_en_i,
    input  logic [CW-1:0] col_i,
    input  logic [GW-1:0] gray_i,
    input  logic          bottom_i,
    input  logic          end_row_i,
    input  logic [TH-1:0] prev_bits_i,
    output logic [TH-1:0] dec_bits_o,
    output logic          dec_we_o
);
    localparam int AW     = clog2(KH * KV * ((1 << GW) - 1) + 1);
    localparam int W_LAST = last_len(H_WIDTH, KH);
    localparam int H_LAST = last_len(V_HEIGHT, KV);

    logic [AW-1:0] acc_q [TH];

    always_ff @(posedge vin_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < TH; c++) acc_q[c] <= '0;
        end else begin
            for (int c = 0; c < TH; c++) begin
                if (clr_i || end_row_i)
                    acc_q[c] <= '0;
                else if (acc_en_i && col_i == CW'(c))
                    acc_q[c] <= acc_q[c] + AW'(gray_i);
            end
        end
    end

    for (genvar c = 0; c < TH; c++) begin : g_col
        localparam int W      = (c == TH - 1) ? W_LAST : KH;
        localparam int N_FULL = W * KV;
        localparam int N_BOT  = W * H_LAST;
        int   sum;
        int   n;
        logic bright;

        always_comb begin
            sum = 32'(acc_q[c]);
            n   = bottom_i ? N_BOT : N_FULL;
`ifdef TILE_HYST_EN
            if (sum > n * (THR + HYST))
                bright = 1'b1;
            else if (sum < n * (THR - HYST))
                bright = 1'b0;
            else
                bright = prev_bits_i[c];
`else
            bright = (sum > n * THR);
`endif
        end

        assign dec_bits_o[c] = bright;
    end

`ifndef TILE_HYST_EN
    logic unused_prev;
    assign unused_prev = ^prev_bits_i;
`endif

    assign dec_we_o = end_row_i;

endmodule

// File: rtl/tile_dark_mixer.sv
// Tile-based dark-mode mixer: per-tile brightness from frame N drives pixel inversion in frame N+1.
// Build with TILE_HYST_EN to enable hysteresis on the per-tile bright decision.
module tile_dark_mixer
    import tile_dark_mixer_pkg::*;
#(
    parameter int H_WIDTH  = 1920,
    parameter int V_HEIGHT = 1080,
    parameter int KH       = 30,
    parameter int KV       = 30,
    parameter int GW       = 3,
    parameter int THR      = 4,
    parameter int HYST     = 1,
    parameter int DW       = 24
) (
    input  logic              vin_clk_i,
    input  logic              rst_n,
    tile_dark_mixer_if.slave  vin,
    tile_dark_mixer_if.master vout,
    input  logic [GW-1:0]     gray_i,
    input  logic [1:0]        mode_i,
    input  logic              hold_i,
    output logic [1:0]        mode_o,
    output logic              frame_done_o
);
    localparam int TH     = ceil_div(H_WIDTH, KH);
    localparam int TV     = ceil_div(V_HEIGHT, KV);
    localparam int CW     = width_of(TH + 1);
    localparam int RW     = width_of(TV + 1);
    localparam int PW     = width_of(KH);
    localparam int LW     = width_of(KV);
    localparam int W_LAST = last_len(H_WIDTH, KH);
    localparam int H_LAST = last_len(V_HEIGHT, KV);

    logic [PW-1:0] pix_q;
    logic [CW-1:0] col_q;
    logic [LW-1:0] line_q;
    logic [RW-1:0] row_q;
    logic          hs_d, vs_d, synced_q;
    logic          vs_rise, hs_rise, last_col, bottom, pix_wrap, row_live, row_done;
    logic          end_row, acc_en;

    assign vs_rise  = vin.vs & ~vs_d;
    assign hs_rise  = vin.hs & ~hs_d & ~vin.de;
    assign last_col = (col_q == CW'(TH - 1));
    assign bottom   = (row_q == RW'(TV - 1));
    assign pix_wrap = (pix_q == PW'(KH - 1)) || (last_col && pix_q == PW'(W_LAST - 1));
    assign row_live = (row_q < RW'(TV));
    assign row_done = bottom ? (line_q == LW'(H_LAST - 1)) : (line_q == LW'(KV - 1));
    // Nothing is accumulated or decided until a vs has aligned the cursor.
    assign end_row  = synced_q & ~vin.vs & hs_rise & row_live & row_done;
    assign acc_en   = synced_q & ~vin.vs & vin.de & row_live;

    always_ff @(posedge vin_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            pix_q    <= '0;
            col_q    <= '0;
            line_q   <= '0;
            row_q    <= '0;
            hs_d     <= 1'b0;
            vs_d     <= 1'b0;
            synced_q <= 1'b0;
        end else begin
            hs_d <= vin.hs;
            vs_d <= vin.vs;
            if (vin.vs) begin
                pix_q    <= '0;
                col_q    <= '0;
                line_q   <= '0;
                row_q    <= '0;
                synced_q <= 1'b1;
            end else if (vin.de) begin
                if (pix_wrap) begin
                    pix_q <= '0;
                    if (col_q < CW'(TH)) col_q <= col_q + CW'(1);
                end else begin
                    pix_q <= pix_q + PW'(1);
                end
            end else if (hs_rise) begin
                pix_q <= '0;
                col_q <= '0;
                if (row_done) begin
                    line_q <= '0;
                    if (row_live) row_q <= row_q + RW'(1);
                end else begin
                    line_q <= line_q + LW'(1);
                end
            end
        end
    end

    logic [TH-1:0] dec_q [TV];
    logic [TH-1:0] row_bits, dec_bits;
    logic          dec_we, cur_bit;

    tile_accum #(
        .H_WIDTH (H_WIDTH),
        .V_HEIGHT(V_HEIGHT),
        .KH      (KH),
        .KV      (KV),
        .GW      (GW),
        .THR     (THR),
        .HYST    (HYST)
    ) u_accum (
        .vin_clk_i  (vin_clk_i),
        .rst_n      (rst_n),
        .clr_i      (vin.vs),
        .acc_en_i   (acc_en),
        .col_i      (col_q),
        .gray_i     (gray_i),
        .bottom_i   (bottom),
        .end_row_i  (end_row),
        .prev_bits_i(row_bits),
        .dec_bits_o (dec_bits),
        .dec_we_o   (dec_we)
    );

    // Row bits are read for output and hysteresis before the same row is rewritten.
    always_comb begin
        row_bits = '0;
        for (int r = 0; r < TV; r++)
            if (row_q == RW'(r)) row_bits = dec_q[r];
    end

    always_comb begin
        cur_bit = 1'b0;
        for (int c = 0; c < TH; c++)
            if (col_q == CW'(c)) cur_bit = row_bits[c];
    end

    mode_e mode_q;
    logic  frame_done_q, inv;

    always_ff @(posedge vin_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < TV; r++) dec_q[r] <= '0;
            mode_q       <= MODE_BLK_DARK;
            frame_done_q <= 1'b0;
        end else begin
            if (dec_we)
                for (int r = 0; r < TV; r++)
                    if (row_q == RW'(r)) dec_q[r] <= dec_bits;
            if (vs_rise) mode_q <= mode_e'(mode_i);
            frame_done_q <= end_row & bottom;
        end
    end

    always_comb begin
        case (mode_q)
            MODE_DIRECT:   inv = 1'b0;
            MODE_INV:      inv = 1'b1;
            MODE_BLK_DARK: inv = cur_bit;
            default:       inv = ~cur_bit;
        endcase
        if (hold_i) inv = 1'b0;
    end

    logic          s1_hs, s1_vs, s1_de, s1_inv;
    logic [DW-1:0] s1_data;
    logic          o_hs, o_vs, o_de;
    logic [DW-1:0] o_data;

    always_ff @(posedge vin_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            s1_hs   <= 1'b0;
            s1_vs   <= 1'b0;
            s1_de   <= 1'b0;
            s1_inv  <= 1'b0;
            s1_data <= '0;
            o_hs    <= 1'b0;
            o_vs    <= 1'b0;
            o_de    <= 1'b0;
            o_data  <= '0;
        end else begin
            s1_hs   <= vin.hs;
            s1_vs   <= vin.vs;
            s1_de   <= vin.de;
            s1_inv  <= inv;
            s1_data <= vin.data;
            o_hs    <= s1_hs;
            o_vs    <= s1_vs;
            o_de    <= s1_de;
            o_data  <= s1_data ^ {DW{s1_inv}};
        end
    end

    assign vout.hs      = o_hs;
    assign vout.vs      = o_vs;
    assign vout.de      = o_de;
    assign vout.data    = o_data;
    assign mode_o       = mode_q;
    assign frame_done_o = frame_done_q;

endmodule
